// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter.
//
// Stores to the register window feed a small TX FIFO; a bit-timing FSM
// drains it onto the serial line, LSB first, with zero gap between
// back-to-back frames. Read data is registered (one-cycle latency) and is
// zero whenever the previous-cycle address was outside the window, so it
// can be OR-combined with other slaves.
//
// Register window (word offsets from BASE_ADDR):
//   0 DATA   (W)  push d_wr_data[7:0] when d_we[0]; reads 0
//   1 STATUS (RW) [0] busy [1] full [2] empty [3] ovf (sticky) [7:4] count;
//                 write d_we[0] with d_wr_data[3]=1 clears ovf
//   2 DIV    (RW) [15:0] clock cycles per bit, per-lane writable, min 2
//   3 reserved
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-high reset
//   d_addr     byte address from the core data port
//   d_we       byte-lane write enables
//   d_wr_data  store data
//   d_rd_data  registered read data
//   tx         serial output, idle high
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     bcnt_q, bcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      sh_q, sh_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     divreg_q, divreg_d;
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic            sel;
  logic [1:0]      off;
  logic            push_req, clr_ovf, div_wr;
  logic            pop, push_ok, ovf_set;
  logic            empty, full;
  logic [PW-1:0]   count;
  logic [7:0]      head;
  logic [15:0]     div_wval;
  logic            unused_bits;

  // Address decode; d_addr[1:0] plays no part in register selection.
  assign sel      = (d_addr[31:4] == BASE_ADDR[31:4]);
  assign off      = d_addr[3:2];
  assign push_req = sel && (off == 2'd0) && d_we[0];
  assign clr_ovf  = sel && (off == 2'd1) && d_we[0] && d_wr_data[3];
  assign div_wr   = sel && (off == 2'd2) && (d_we[1:0] != 2'b00);

  assign unused_bits = ^{d_addr[1:0], d_we[3:2], d_wr_data[31:16]};

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

  // Bit-timing FSM. bcnt counts down div_q-1..0 for each bit period; a new
  // byte is popped either from IDLE or straight out of the last STOP cycle.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    div_d   = div_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          div_d   = divreg_q;
          bcnt_d  = divreg_q - 16'd1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == 16'd0) begin
          state_d = S_DATA;
          bidx_d  = 3'd0;
          bcnt_d  = div_q - 16'd1;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bcnt_q == 16'd0) begin
          sh_d   = {1'b0, sh_q[7:1]};
          bcnt_d = div_q - 16'd1;
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bcnt_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            div_d   = divreg_q;
            bcnt_d  = divreg_q - 16'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so tx comes straight from a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping, sticky overflow, DIV register and read mux.
  always_comb begin
    // A push into a full FIFO still fits when the same cycle pops a slot.
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + (push_ok ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    div_wval = divreg_q;
    if (d_we[0]) div_wval[7:0]  = d_wr_data[7:0];
    if (d_we[1]) div_wval[15:8] = d_wr_data[15:8];
    divreg_d = divreg_q;
    if (div_wr) begin
      divreg_d = (div_wval < 16'd2) ? 16'd2 : div_wval;
    end

    rd_data_d = '0;
    if (sel) begin
      case (off)
        2'd1:    rd_data_d = {24'h0, 4'(count), ovf_q, empty, full,
                              (state_q != S_IDLE)};
        2'd2:    rd_data_d = {16'h0, divreg_q};
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      bidx_q    <= '0;
      sh_q      <= '0;
      div_q     <= CLK_DIV;
      divreg_q  <= CLK_DIV;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bidx_q    <= bidx_d;
      sh_q      <= sh_d;
      div_q     <= div_d;
      divreg_q  <= divreg_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // FIFO storage holds payload only; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= d_wr_data[7:0];
    end
  end

  assign d_rd_data = rd_data_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: register vector table, directed frame
// sequences and randomized traffic checked against a frame-timeline model.
module tb_uart_tx_mmio;

  localparam logic [31:0] B     = 32'h1000_0000;
  localparam logic [15:0] CDIV  = 16'd868;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;
  logic        tx;

  uart_tx_mmio #(
    .BASE_ADDR (B),
    .CLK_DIV   (CDIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wr_data(d_wr_data),
    .d_rd_data(d_rd_data),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting bytes plus the frame currently on
  // the line, described by its start offset, bit time and byte.
  logic [7:0]  mq[$];
  bit          m_active;
  int          m_pos;
  int          m_div;
  int          m_divreg;
  logic [7:0]  m_byte;
  logic        m_ovf;
  logic [31:0] exp_rd;
  bit          chk_en = 0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a[31:4] == B[31:4]) begin
      if (a[3:2] == 2'd1) begin
        v[0]   = m_active;
        v[1]   = (mq.size() == DEPTH);
        v[2]   = (mq.size() == 0);
        v[3]   = m_ovf;
        v[7:4] = 4'(mq.size());
      end else if (a[3:2] == 2'd2) begin
        v[15:0] = 16'(m_divreg);
      end
    end
    return v;
  endfunction

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / m_div;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_pos    = 0;
    m_div    = int'(CDIV);
    m_divreg = int'(CDIV);
    m_byte   = 8'h0;
    m_ovf    = 1'b0;
    exp_rd   = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] rd_next;
    logic        sel, push, clr, ending, pop, full_pre, set_ovf;
    logic [15:0] v;
    rd_next  = model_read(d_addr);
    sel      = (d_addr[31:4] == B[31:4]);
    push     = sel && (d_addr[3:2] == 2'd0) && d_we[0];
    clr      = sel && (d_addr[3:2] == 2'd1) && d_we[0] && d_wr_data[3];
    ending   = m_active && (m_pos == 10 * m_div - 1);
    pop      = (!m_active || ending) && (mq.size() > 0);
    full_pre = (mq.size() == DEPTH);
    set_ovf  = push && full_pre && !pop;
    if (pop) begin
      m_byte   = mq.pop_front();
      m_active = 1;
      m_pos    = 0;
      m_div    = m_divreg;
    end else if (m_active) begin
      if (ending) m_active = 0;
      else m_pos = m_pos + 1;
    end
    if (push && !set_ovf) mq.push_back(d_wr_data[7:0]);
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (sel && (d_addr[3:2] == 2'd2) && (d_we[1:0] != 2'b00)) begin
      v = 16'(m_divreg);
      if (d_we[0]) v[7:0]  = d_wr_data[7:0];
      if (d_we[1]) v[15:8] = d_wr_data[15:8];
      if (v < 16'd2) v = 16'd2;
      m_divreg = int'(v);
    end
    exp_rd = rd_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Continuous comparison of the line and read bus against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("tx_line", {31'h0, tx}, {31'h0, model_tx()});
        chk("rd_bus", d_rd_data, exp_rd);
      end
    end
  end

  // One bus cycle: drive at a falling edge, return at the next falling edge
  // with the read result (if any) visible on d_rd_data.
  task automatic cyc(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    d_addr    = a;
    d_we      = we;
    d_wr_data = wd;
    @(negedge clk);
    d_addr    = 32'h0;
    d_we      = 4'h0;
    d_wr_data = 32'h0;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[17];
  logic [9:0]  frame;
  logic        tx_hist [0:103];
  int          ones;
  int          r;
  logic [31:0] ra;
  logic [3:0]  rwe;
  logic [31:0] rwd;

  initial begin
    vt[0]  = '{B + 32'h4,  4'h0, 32'h0,        B + 32'h4,  32'h04};
    vt[1]  = '{B + 32'h8,  4'h0, 32'h0,        B + 32'h8,  32'h364};
    vt[2]  = '{B,          4'h0, 32'h0,        B,          32'h0};
    vt[3]  = '{B + 32'hC,  4'h0, 32'h0,        B + 32'hC,  32'h0};
    vt[4]  = '{B + 32'h14, 4'h0, 32'h0,        B + 32'h14, 32'h0};
    vt[5]  = '{B + 32'h8,  4'h3, 32'h0,        B + 32'h8,  32'h2};
    vt[6]  = '{B + 32'h8,  4'h2, 32'h100,      B + 32'h8,  32'h102};
    vt[7]  = '{B + 32'h8,  4'h1, 32'h5,        B + 32'h8,  32'h105};
    vt[8]  = '{B + 32'h8,  4'h0, 32'hFFFF,     B + 32'h8,  32'h105};
    vt[9]  = '{B + 32'h8,  4'h3, 32'h1,        B + 32'h8,  32'h2};
    vt[10] = '{B + 32'h8,  4'hF, 32'hABCD0007, B + 32'h8,  32'h7};
    vt[11] = '{B + 32'hC,  4'hF, 32'hFFFFFFFF, B + 32'hC,  32'h0};
    vt[12] = '{B + 32'h10, 4'hF, 32'h41,       B + 32'h4,  32'h04};
    vt[13] = '{B + 32'hB,  4'h3, 32'h4,        B + 32'h8,  32'h4};
    vt[14] = '{B + 32'h4,  4'h1, 32'h8,        B + 32'h4,  32'h04};
    vt[15] = '{B,          4'h0, 32'h55,       B + 32'h4,  32'h04};
    vt[16] = '{32'h2000_0004, 4'h1, 32'h8,     B + 32'h8,  32'h4};

    rst = 1'b1;
    d_addr = 32'h0;
    d_we = 4'h0;
    d_wr_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_rd", d_rd_data, 32'h0);
    rst = 1'b0;
    chk_en = 1;

    // Register access vectors.
    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].waddr, vt[i].we, vt[i].wdata);
      cyc(vt[i].raddr, 4'h0, 32'h0);
      chk($sformatf("vec%0d", i), d_rd_data, vt[i].exp);
    end

    // 0xA5 at DIV=4: start bit, LSB-first data, stop bit, 4 cycles each.
    frame = {1'b1, 8'hA5, 1'b0};
    cyc(B, 4'h1, 32'hA5);
    chk("a5_pre", {31'h0, tx}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      cyc(32'h0, 4'h0, 32'h0);
      chk($sformatf("a5_bit%0d", k), {31'h0, tx}, {31'h0, frame[k/4]});
    end
    cyc(32'h0, 4'h0, 32'h0);
    chk("a5_idle", {31'h0, tx}, 32'h1);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("a5_status", d_rd_data, 32'h04);

    // Nine zero bytes back-to-back at DIV=2: only stop bits are high,
    // so a gapless train has exactly 9*2 high cycles over 180 cycles.
    cyc(B + 32'h8, 4'h3, 32'h2);
    ones = 0;
    cyc(B, 4'h1, 32'h0);
    for (int i = 1; i <= 180; i++) begin
      if (i <= 8) cyc(B, 4'h1, 32'h0);
      else if (i == 9) begin
        cyc(B + 32'h4, 4'h0, 32'h0);
        chk("nine_status", d_rd_data, 32'h83);
      end else cyc(32'h0, 4'h0, 32'h0);
      if (tx) ones = ones + 1;
    end
    chk("nine_high_cycles", ones, 32'd18);
    repeat (3) cyc(32'h0, 4'h0, 32'h0);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("nine_done", d_rd_data, 32'h04);

    // Overflow, ovf clear, then a push landing exactly on a pop while full.
    cyc(B, 4'h1, 32'h11);
    cyc(32'h0, 4'h0, 32'h0);
    cyc(32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) cyc(B, 4'h1, 32'h20 + 32'(i));
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("ovf_status", d_rd_data, 32'h8B);
    cyc(B + 32'h4, 4'h1, 32'h8);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("ovf_cleared", d_rd_data, 32'h83);
    repeat (5) cyc(32'h0, 4'h0, 32'h0);
    cyc(B, 4'h1, 32'h77);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("full_push_pop", d_rd_data, 32'h83);
    repeat (200) cyc(32'h0, 4'h0, 32'h0);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("ovf_drained", d_rd_data, 32'h04);

    // DIV rewritten to 6 during a DIV=4 frame.
    cyc(B + 32'h8, 4'h3, 32'h4);
    for (int e = 0; e < 104; e++) begin
      if (e == 0) cyc(B, 4'h1, 32'h3C);
      else if (e == 1) cyc(B, 4'h1, 32'hC3);
      else if (e == 10) cyc(B + 32'h8, 4'h3, 32'h6);
      else if (e == 100 || e == 102) cyc(B + 32'h4, 4'h0, 32'h0);
      else if (e == 103) cyc(B + 32'h8, 4'h0, 32'h0);
      else cyc(32'h0, 4'h0, 32'h0);
      tx_hist[e] = tx;
      if (e == 100) chk("div_busy_end", d_rd_data, 32'h05);
      if (e == 102) chk("div_idle", d_rd_data, 32'h04);
      if (e == 103) chk("div_reads6", d_rd_data, 32'h6);
    end
    chk("div_old_bit1", {31'h0, tx_hist[12]}, 32'h0);
    chk("div_old_bit2", {31'h0, tx_hist[13]}, 32'h1);
    chk("div_stop1", {31'h0, tx_hist[40]}, 32'h1);
    chk("div_start2a", {31'h0, tx_hist[41]}, 32'h0);
    chk("div_start2b", {31'h0, tx_hist[46]}, 32'h0);
    chk("div_bit0_2", {31'h0, tx_hist[47]}, 32'h1);

    // Randomized register traffic against the model.
    cyc(B + 32'h8, 4'h3, 32'h3);
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 9);
      ra  = 32'h0;
      rwe = 4'h0;
      rwd = $urandom;
      case (r)
        0, 1, 2, 3: begin ra = B | 32'($urandom_range(0, 3)); rwe = 4'($urandom); end
        4:          ra = B + 32'h4;
        5:          begin ra = B + 32'h8; rwe = 4'h3; rwd = 32'($urandom_range(0, 5)); end
        6:          begin ra = B + 32'h4; rwe = 4'($urandom); end
        7:          begin ra = B + 32'hC; rwe = 4'hF; end
        8:          begin ra = B + 32'h10 + 32'($urandom_range(0, 15)); rwe = 4'($urandom); end
        default:    ra = B;
      endcase
      cyc(ra, rwe, rwd);
    end
    repeat (600) cyc(32'h0, 4'h0, 32'h0);
    cyc(B + 32'h4, 4'h1, 32'h8);
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("rand_drained", d_rd_data, 32'h04);

    // Reset in the middle of data bit 3 of a 0x00 frame.
    cyc(B + 32'h8, 4'h3, 32'h4);
    cyc(B, 4'h1, 32'h0);
    repeat (18) cyc(32'h0, 4'h0, 32'h0);
    chk("rst_bit3_low", {31'h0, tx}, 32'h0);
    #2 rst = 1'b1;
    #1 chk("rst_async_tx", {31'h0, tx}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    cyc(B + 32'h4, 4'h0, 32'h0);
    chk("rst_status", d_rd_data, 32'h04);
    cyc(B + 32'h8, 4'h0, 32'h0);
    chk("rst_div", d_rd_data, 32'(CDIV));
    chk("rst_tx_idle", {31'h0, tx}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
